// File: rtl/angle_tracker.sv
// Wrap-aware first-order IIR bearing smoother for the 16-bit binary-angle stream,
// with lock acquisition and outlier rejection.
module angle_tracker #(
  parameter int unsigned SHIFT         = 2,
  parameter logic [15:0] LOCK_THRESH   = 16'h0200,
  parameter int unsigned LOCK_COUNT    = 8,
  parameter logic [15:0] UNLOCK_THRESH = 16'h1000,
  parameter int unsigned UNLOCK_COUNT  = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [15:0] angle_in,
  output logic [15:0] angle_out,
  output logic        out_valid,
  output logic        locked,
  output logic        outlier
);

  localparam logic [1:0] ST_INIT    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [7:0] LOCK_TERM   = 8'(LOCK_COUNT);
  localparam logic [7:0] UNLOCK_TERM = 8'(UNLOCK_COUNT);

  logic [1:0]         state;
  logic [15:0]        est;
  logic [7:0]         good_cnt;
  logic [7:0]         bad_cnt;

  logic signed [15:0] diff;
  logic signed [15:0] upd;
  logic [15:0]        absd;
  logic [15:0]        est_upd;
  logic               good_hit;
  logic               bad_hit;
  logic [7:0]         good_next;
  logic [7:0]         bad_next;

  // Modular subtraction read as signed yields the shortest-path error across the wrap.
  always_comb begin
    diff = signed'(angle_in - est);
    if (diff == 16'sh8000)
      absd = 16'h7FFF;
    else if (diff[15])
      absd = unsigned'(-diff);
    else
      absd = unsigned'(diff);
    upd       = diff >>> SHIFT;
    est_upd   = est + unsigned'(upd);
    good_hit  = (absd < LOCK_THRESH);
    bad_hit   = (absd > UNLOCK_THRESH);
    good_next = good_cnt + 8'd1;
    bad_next  = bad_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      state     <= ST_INIT;
      est       <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      out_valid <= 1'b0;
      outlier   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      outlier   <= 1'b0;
      if (in_valid) begin
        case (state)
          ST_INIT: begin
            est      <= angle_in;
            good_cnt <= '0;
            bad_cnt  <= '0;
            state    <= ST_ACQUIRE;
          end
          ST_ACQUIRE: begin
            est <= est_upd;
            if (good_hit) begin
              if (good_next >= LOCK_TERM) begin
                good_cnt <= '0;
                state    <= ST_LOCKED;
              end else begin
                good_cnt <= good_next;
              end
            end else begin
              good_cnt <= '0;
            end
          end
          ST_LOCKED: begin
            if (bad_hit) begin
              outlier <= 1'b1;
              // Persistent outliers mean the target moved: snap and re-acquire.
              if (bad_next >= UNLOCK_TERM) begin
                est     <= angle_in;
                bad_cnt <= '0;
                state   <= ST_ACQUIRE;
              end else begin
                bad_cnt <= bad_next;
              end
            end else begin
              est     <= est_upd;
              bad_cnt <= '0;
            end
          end
          default: state <= ST_INIT;
        endcase
      end
    end
  end

  assign angle_out = est;
  assign locked    = (state == ST_LOCKED);

endmodule

// File: tb/tb_angle_tracker.sv
// Directed-vector bench for angle_tracker: default-parameter table plus a short
// hand sequence on a LOCK_COUNT=1 / UNLOCK_COUNT=1 / SHIFT=0 instance.
module tb_angle_tracker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, clear, in_valid;
  logic [15:0] angle_in;
  logic [15:0] angle_out;
  logic        out_valid, locked, outlier;

  logic        resetn2, in_valid2;
  logic [15:0] angle_in2;
  logic [15:0] angle_out2;
  logic        out_valid2, locked2, outlier2;

  angle_tracker dut (
    .clk(clk), .resetn(resetn), .clear(clear), .in_valid(in_valid),
    .angle_in(angle_in), .angle_out(angle_out), .out_valid(out_valid),
    .locked(locked), .outlier(outlier)
  );

  angle_tracker #(
    .SHIFT(0), .LOCK_THRESH(16'h0200), .LOCK_COUNT(1),
    .UNLOCK_THRESH(16'h1000), .UNLOCK_COUNT(1)
  ) dut2 (
    .clk(clk), .resetn(resetn2), .clear(1'b0), .in_valid(in_valid2),
    .angle_in(angle_in2), .angle_out(angle_out2), .out_valid(out_valid2),
    .locked(locked2), .outlier(outlier2)
  );

  typedef struct {
    logic        rn;
    logic        clr;
    logic        vld;
    logic [15:0] ang;
    logic        ov;
    logic [15:0] out;
    logic        lk;
    logic        ol;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(logic rn, logic clr, logic vld, logic [15:0] ang,
                              logic ov, logic [15:0] out, logic lk, logic ol);
    vec_t v;
    v.rn = rn; v.clr = clr; v.vld = vld; v.ang = ang;
    v.ov = ov; v.out = out; v.lk = lk; v.ol = ol;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int idx, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic step2(logic rn, logic vld, logic [15:0] ang, int idx,
                       logic ov, logic [15:0] out, logic lk, logic ol);
    resetn2 = rn; in_valid2 = vld; angle_in2 = ang;
    @(posedge clk); #1;
    chk("b_out_valid", idx, 16'(out_valid2), 16'(ov));
    chk("b_angle_out", idx, angle_out2, out);
    chk("b_locked",    idx, 16'(locked2), 16'(lk));
    chk("b_outlier",   idx, 16'(outlier2), 16'(ol));
  endtask

  initial begin
    resetn = 1'b0; clear = 1'b0; in_valid = 1'b0; angle_in = '0;
    resetn2 = 1'b0; in_valid2 = 1'b0; angle_in2 = '0;

    // reset and first load
    add(0,0,0,16'h0000, 0,16'h0000,0,0);
    add(1,0,1,16'h1234, 1,16'h1234,0,0);
    add(1,0,0,16'h0000, 0,16'h1234,0,0);
    // step response from est=0
    add(1,1,1,16'h5555, 0,16'h0000,0,0);
    add(1,0,1,16'h0000, 1,16'h0000,0,0);
    add(1,0,1,16'h1000, 1,16'h0400,0,0);
    add(1,0,1,16'h1000, 1,16'h0700,0,0);
    add(1,0,1,16'h1000, 1,16'h0940,0,0);
    // wrap, both directions
    add(0,0,1,16'h7777, 0,16'h0000,0,0);
    add(1,0,1,16'hFF00, 1,16'hFF00,0,0);
    add(1,0,1,16'h0100, 1,16'hFF80,0,0);
    add(1,1,0,16'h0000, 0,16'h0000,0,0);
    add(1,0,1,16'h0100, 1,16'h0100,0,0);
    add(1,0,1,16'hFF00, 1,16'h0080,0,0);
    // lock after 8 good samples
    add(1,1,0,16'h0000, 0,16'h0000,0,0);
    add(1,0,1,16'h4000, 1,16'h4000,0,0);
    for (int i = 0; i < 7; i++) add(1,0,1,16'h4000, 1,16'h4000,0,0);
    add(1,0,1,16'h4000, 1,16'h4000,1,0);
    add(1,0,0,16'h0000, 0,16'h4000,1,0);
    // outliers: 3 rejected, 4th snaps (diff -32768 saturates)
    for (int i = 0; i < 3; i++) add(1,0,1,16'hC000, 1,16'h4000,1,1);
    add(1,0,1,16'hC000, 1,16'hC000,0,1);
    add(1,0,1,16'hC000, 1,16'hC000,0,0);
    // good-count restart on a 0x0300 error at sample 5
    add(1,1,0,16'h0000, 0,16'h0000,0,0);
    add(1,0,1,16'h1000, 1,16'h1000,0,0);
    for (int i = 0; i < 4; i++) add(1,0,1,16'h1000, 1,16'h1000,0,0);
    add(1,0,1,16'h1300, 1,16'h10C0,0,0);
    for (int i = 0; i < 7; i++) add(1,0,1,16'h10C0, 1,16'h10C0,0,0);
    add(1,0,1,16'h10C0, 1,16'h10C0,1,0);
    // bad-count reset by an in-range sample; |diff| == UNLOCK_THRESH is not an outlier
    add(1,0,1,16'h9000, 1,16'h10C0,1,1);
    add(1,0,1,16'h20C0, 1,16'h14C0,1,0);
    for (int i = 0; i < 3; i++) add(1,0,1,16'h9000, 1,16'h14C0,1,1);
    add(1,0,1,16'h9000, 1,16'h9000,0,1);
    // resetn with in_valid mid-stream, then INIT load and floor of negative diff
    add(0,0,1,16'h9000, 0,16'h0000,0,0);
    add(1,0,1,16'h2222, 1,16'h2222,0,0);
    add(1,0,1,16'h2221, 1,16'h2221,0,0);
    // clear beats in_valid, resetn beats clear
    add(1,1,1,16'h3333, 0,16'h0000,0,0);
    add(1,0,1,16'h0ABC, 1,16'h0ABC,0,0);
    add(0,1,1,16'h1111, 0,16'h0000,0,0);

    foreach (vecs[i]) begin
      resetn = vecs[i].rn; clear = vecs[i].clr;
      in_valid = vecs[i].vld; angle_in = vecs[i].ang;
      @(posedge clk); #1;
      chk("out_valid", i, 16'(out_valid), 16'(vecs[i].ov));
      chk("angle_out", i, angle_out, vecs[i].out);
      chk("locked",    i, 16'(locked), 16'(vecs[i].lk));
      chk("outlier",   i, 16'(outlier), 16'(vecs[i].ol));
    end
    in_valid = 1'b0;

    // LOCK_COUNT=1 locks on first good sample; UNLOCK_COUNT=1 snaps on first outlier
    step2(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0);
    step2(1, 1, 16'h0100, 1, 1, 16'h0100, 0, 0);
    step2(1, 1, 16'h0100, 2, 1, 16'h0100, 1, 0);
    step2(1, 1, 16'h8100, 3, 1, 16'h8100, 0, 1);
    step2(1, 1, 16'h8150, 4, 1, 16'h8150, 1, 0);
    step2(1, 0, 16'h0000, 5, 0, 16'h8150, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
